// File: rtl/pipelined_adder.sv
// WIDTH-bit adder in STAGES ripple chunks, latency STAGES; all stages hold when out_valid && !out_ready (in_ready = advance).
// Optional subtract port/logic enabled by PIPELINED_ADDER_SUB_EN.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;
`ifdef PIPELINED_ADDER_SUB_EN
    logic [STAGES-1:0] sub_q, sub_d;
    logic              op_sub;
`endif

    logic [WIDTH-1:0] op_a, op_b, op_s;
    logic             op_c;
    logic [CHUNK-1:0] b_eff;
    logic [CHUNK:0]   chunk_sum;
    logic             advance;

    assign out_valid = vld_q[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    always_comb begin
        op_a      = '0;
        op_b      = '0;
        op_s      = '0;
        op_c      = 1'b0;
        b_eff     = '0;
        chunk_sum = '0;
        ovf_d     = 1'b0;
        vld_d     = '0;
        c_d       = '0;
`ifdef PIPELINED_ADDER_SUB_EN
        op_sub    = 1'b0;
        sub_d     = '0;
`endif
        for (int k = 0; k < STAGES; k++) begin
            // Stage 0 takes the ports; later stages take what the previous register carried.
            if (k == 0) begin
                op_a     = a;
                op_b     = b;
                op_s     = '0;
                op_c     = cin;
                vld_d[k] = in_valid;
            end else begin
                op_a     = a_q[(k > 0) ? k - 1 : 0];
                op_b     = b_q[(k > 0) ? k - 1 : 0];
                op_s     = s_q[(k > 0) ? k - 1 : 0];
                op_c     = c_q[(k > 0) ? k - 1 : 0];
                vld_d[k] = vld_q[(k > 0) ? k - 1 : 0];
            end
`ifdef PIPELINED_ADDER_SUB_EN
            op_sub = (k == 0) ? sub : sub_q[(k > 0) ? k - 1 : 0];
            if (k == 0) op_c = cin ^ sub;
            b_eff  = op_b[k*CHUNK +: CHUNK] ^ {CHUNK{op_sub}};
            sub_d[k] = op_sub;
`else
            b_eff  = op_b[k*CHUNK +: CHUNK];
`endif
            chunk_sum = {1'b0, op_a[k*CHUNK +: CHUNK]} + {1'b0, b_eff}
                      + {{CHUNK{1'b0}}, op_c};
            op_s[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            s_d[k] = op_s;
            c_d[k] = chunk_sum[CHUNK];
            a_d[k] = op_a;
            b_d[k] = op_b;
            if (k == STAGES - 1) begin
                ovf_d = (op_a[WIDTH-1] == b_eff[CHUNK-1]) &&
                        (op_s[WIDTH-1] != op_a[WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
            sub_q <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
`ifdef PIPELINED_ADDER_SUB_EN
            sub_q <= sub_d;
`endif
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

endmodule
